// File: rtl/grid_sweep_scheduler.sv
// grid_sweep_scheduler: row-serial neighbour-count removal passes over a DEPTH x WIDTH occupancy grid
module grid_sweep_scheduler #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int MAX_PASSES = 256,
  localparam int CW = $clog2(WIDTH*DEPTH+1),
  localparam int PW = $clog2(MAX_PASSES+1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_row,
  input  logic             start,
  output logic             busy,
  output logic             pass_valid,
  output logic [CW-1:0]    pass_removed,
  output logic [PW-1:0]    pass_count,
  output logic [CW-1:0]    total_count,
  output logic             done,
  output logic             limit_hit,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_row
);
  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_LOADED = 3'd2,
                         S_SWEEP = 3'd3, S_CHECK = 3'd4, S_DONE = 3'd5;
  logic [2:0]       r_state;
  logic [AW-1:0]    r_idx;
  logic [WIDTH-1:0] r_grid [DEPTH];
  logic [WIDTH-1:0] r_prev;
  logic [CW-1:0]    r_acc, r_last, r_total;
  logic [PW-1:0]    r_pc;
  logic             r_lh;
  logic [WIDTH-1:0] r_rd;
  logic             w_last, w_ld, w_lim;
  logic [AW-1:0]    w_nxt;
  logic [WIDTH-1:0] w_up, w_mid, w_dn, w_clr, w_new;
  logic [WIDTH+1:0] w_pu, w_pm, w_pd;
  logic [3:0]       w_cnt [WIDTH];
  logic [CW-1:0]    w_pop;
  assign load_ready   = r_state == S_IDLE || r_state == S_LOAD || r_state == S_DONE;
  assign busy         = r_state == S_SWEEP || r_state == S_CHECK;
  assign done         = r_state == S_DONE;
  assign pass_valid   = r_state == S_CHECK;
  assign pass_removed = pass_valid ? r_acc : r_last;
  assign pass_count   = r_pc;
  assign total_count  = r_total;
  assign limit_hit    = r_lh;
  assign rd_row       = r_rd;
  assign w_last = r_idx == AW'(DEPTH-1);
  assign w_ld   = load_valid && load_ready;
  assign w_lim  = PW'(r_pc + 1'b1) == PW'(MAX_PASSES);
  assign w_nxt  = w_last ? r_idx : r_idx + 1'b1;
  // Row above was already overwritten this pass, so its pass-start value comes from r_prev
  assign w_up   = r_idx == '0 ? '0 : r_prev;
  assign w_mid  = r_grid[r_idx];
  assign w_dn   = w_last ? '0 : r_grid[w_nxt];
  assign w_pu   = {1'b0, w_up, 1'b0};
  assign w_pm   = {1'b0, w_mid, 1'b0};
  assign w_pd   = {1'b0, w_dn, 1'b0};
  assign w_new  = w_mid & ~w_clr;
  // Per-column 8-neighbour count over the zero-padded 3-row window and removal popcount
  always_comb begin
    w_pop = '0;
    for (int j = 0; j < WIDTH; j++) begin
      w_cnt[j] = 4'(w_pu[j]) + 4'(w_pu[j+1]) + 4'(w_pu[j+2]) + 4'(w_pm[j]) +
                 4'(w_pm[j+2]) + 4'(w_pd[j]) + 4'(w_pd[j+1]) + 4'(w_pd[j+2]);
      w_clr[j] = w_mid[j] && w_cnt[j] < 4'd4;
      w_pop = w_pop + CW'(w_clr[j]);
    end
  end
  // Grid storage: written by the loader or by the sweep, one row per cycle
  always_ff @(posedge clk) begin
    if (!reset && w_ld) r_grid[r_idx] <= load_row;
    else if (!reset && r_state == S_SWEEP) r_grid[r_idx] <= w_new;
  end
  // Control FSM, pass accounting and registered readback
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_prev  <= '0;
      r_acc   <= '0;
      r_last  <= '0;
      r_total <= '0;
      r_pc    <= '0;
      r_lh    <= 1'b0;
      r_rd    <= '0;
    end else begin
      r_rd <= r_grid[rd_addr];
      case (r_state)
        S_IDLE, S_LOAD, S_DONE: if (w_ld) begin
          r_idx   <= w_last ? '0 : r_idx + 1'b1;
          r_state <= w_last ? S_LOADED : S_LOAD;
          r_lh    <= 1'b0;
        end
        S_LOADED: if (start) begin
          r_state <= S_SWEEP;
          r_idx   <= '0;
          r_pc    <= '0;
          r_total <= '0;
          r_acc   <= '0;
        end
        S_SWEEP: begin
          r_prev  <= w_mid;
          r_acc   <= r_acc + w_pop;
          r_idx   <= w_last ? '0 : r_idx + 1'b1;
          r_state <= w_last ? S_CHECK : S_SWEEP;
        end
        S_CHECK: begin
          r_last  <= r_acc;
          r_total <= r_total + r_acc;
          r_pc    <= r_pc + 1'b1;
          r_acc   <= '0;
          r_state <= (r_acc == '0 || w_lim) ? S_DONE : S_SWEEP;
          r_lh    <= r_acc != '0 && w_lim;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_grid_sweep_scheduler.sv
// tb_grid_sweep_scheduler: random and directed grids against a cell-level reference model, two pass limits
module tb_grid_sweep_scheduler;
  logic       clk = 1'b0, reset, load_valid, start;
  logic [3:0] load_row;
  logic [1:0] rd_addr;
  logic       a_load_ready, a_busy, a_pass_valid, a_done, a_limit_hit;
  logic [4:0] a_pass_removed, a_total_count;
  logic [8:0] a_pass_count;
  logic [3:0] a_rd_row;
  logic       b_load_ready, b_busy, b_pass_valid, b_done, b_limit_hit;
  logic [4:0] b_pass_removed, b_total_count;
  logic [0:0] b_pass_count;
  logic [3:0] b_rd_row;
  int         n_cmp = 0, n_bad = 0;
  logic [3:0] g_rows [4];
  int         m_np [2], m_tot [2], m_rem [2][20];
  bit         m_lh [2];
  logic [3:0] m_fin [2][4];

  grid_sweep_scheduler #(.WIDTH(4), .DEPTH(4), .MAX_PASSES(256)) u_a (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(a_load_ready),
    .load_row(load_row), .start(start), .busy(a_busy), .pass_valid(a_pass_valid),
    .pass_removed(a_pass_removed), .pass_count(a_pass_count), .total_count(a_total_count),
    .done(a_done), .limit_hit(a_limit_hit), .rd_addr(rd_addr), .rd_row(a_rd_row));

  grid_sweep_scheduler #(.WIDTH(4), .DEPTH(4), .MAX_PASSES(1)) u_b (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(b_load_ready),
    .load_row(load_row), .start(start), .busy(b_busy), .pass_valid(b_pass_valid),
    .pass_removed(b_pass_removed), .pass_count(b_pass_count), .total_count(b_total_count),
    .done(b_done), .limit_hit(b_limit_hit), .rd_addr(rd_addr), .rd_row(b_rd_row));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model(input int k, input int maxp);
    bit g [4][4];
    bit ng [4][4];
    int n, rem;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) g[r][c] = g_rows[r][c];
    m_np[k] = 0; m_tot[k] = 0; m_lh[k] = 0;
    forever begin
      rem = 0;
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin
        ng[r][c] = g[r][c];
        if (g[r][c]) begin
          n = 0;
          for (int dr = -1; dr <= 1; dr++) for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r+dr >= 0 && r+dr < 4 && c+dc >= 0 && c+dc < 4)
              if (g[r+dr][c+dc]) n++;
          if (n < 4) begin ng[r][c] = 0; rem++; end
        end
      end
      g = ng;
      m_rem[k][m_np[k]] = rem;
      m_np[k]++;
      m_tot[k] += rem;
      if (rem == 0) break;
      if (m_np[k] == maxp) begin m_lh[k] = 1; break; end
    end
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) m_fin[k][r][c] = g[r][c];
  endtask

  task automatic chk_reset();
    chk("rst_ready", a_load_ready, 1);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_limit", a_limit_hit, 0);
    chk("rst_pv", a_pass_valid, 0);
    chk("rst_removed", a_pass_removed, 0);
    chk("rst_pcount", a_pass_count, 0);
    chk("rst_total", a_total_count, 0);
    chk("rst_rdrow", a_rd_row, 0);
    chk("rst_b_done", b_done, 0);
    chk("rst_b_limit", b_limit_hit, 0);
    chk("rst_b_pcount", b_pass_count, 0);
  endtask

  task automatic load_grid(input bit stress);
    for (int r = 0; r < 4; r++) begin
      load_row = g_rows[r];
      load_valid = 1;
      tick();
      if (stress) begin
        load_valid = 0;
        load_row = 4'($urandom);
        start = (r < 3);
        tick();
        start = 0;
      end
    end
    load_valid = 0;
    chk("loaded_ready", a_load_ready, 0);
    chk("loaded_b_ready", b_load_ready, 0);
    chk("loaded_busy", a_busy, 0);
    if (stress) begin
      load_valid = 1;
      load_row = ~g_rows[0];
      tick();
      load_valid = 0;
      chk("loaded_ignore_busy", a_busy, 0);
      chk("loaded_ignore_ready", a_load_ready, 0);
    end
  endtask

  task automatic run_sweep();
    int mx;
    bit ea, eb;
    mx = m_np[0] > m_np[1] ? m_np[0] : m_np[1];
    start = 1;
    tick();
    start = 0;
    for (int cnt = 1; cnt <= mx*5 + 2; cnt++) begin
      ea = (cnt % 5 == 0) && (cnt / 5 <= m_np[0]);
      eb = (cnt % 5 == 0) && (cnt / 5 <= m_np[1]);
      chk("a_pv", a_pass_valid, ea);
      if (ea) chk("a_removed", a_pass_removed, m_rem[0][cnt/5-1]);
      chk("a_done", a_done, cnt > m_np[0]*5);
      chk("a_busy", a_busy, cnt <= m_np[0]*5);
      chk("b_pv", b_pass_valid, eb);
      if (eb) chk("b_removed", b_pass_removed, m_rem[1][cnt/5-1]);
      chk("b_done", b_done, cnt > m_np[1]*5);
      chk("b_busy", b_busy, cnt <= m_np[1]*5);
      tick();
    end
    chk("a_total", a_total_count, m_tot[0]);
    chk("a_pcount", a_pass_count, m_np[0]);
    chk("a_limit", a_limit_hit, m_lh[0]);
    chk("a_ready_done", a_load_ready, 1);
    chk("a_held_removed", a_pass_removed, m_rem[0][m_np[0]-1]);
    chk("b_total", b_total_count, m_tot[1]);
    chk("b_pcount", b_pass_count, m_np[1]);
    chk("b_limit", b_limit_hit, m_lh[1]);
    chk("b_held_removed", b_pass_removed, m_rem[1][m_np[1]-1]);
    for (int r = 0; r < 4; r++) begin
      rd_addr = 2'(r);
      tick();
      chk("a_rd_row", a_rd_row, m_fin[0][r]);
      chk("b_rd_row", b_rd_row, m_fin[1][r]);
    end
  endtask

  task automatic run_case(input bit stress);
    model(0, 256);
    model(1, 1);
    load_grid(stress);
    run_sweep();
  endtask

  initial begin
    reset = 1; load_valid = 0; start = 0; load_row = '0; rd_addr = '0;
    tick(); tick();
    chk_reset();
    reset = 0;
    for (int r = 0; r < 4; r++) g_rows[r] = 4'h0;
    run_case(0);
    for (int r = 0; r < 4; r++) g_rows[r] = 4'hF;
    run_case(0);
    for (int r = 0; r < 4; r++) g_rows[r] = 4'h0;
    g_rows[1] = 4'b0100;
    run_case(1);
    for (int r = 0; r < 4; r++) g_rows[r] = 4'hF;
    load_grid(0);
    start = 1;
    tick();
    start = 0;
    tick();
    reset = 1;
    tick();
    chk_reset();
    reset = 0;
    run_case(1);
    for (int i = 0; i < 30; i++) begin
      for (int r = 0; r < 4; r++) begin
        case ($urandom_range(0, 2))
          0: g_rows[r] = 4'($urandom);
          1: g_rows[r] = 4'($urandom | $urandom);
          default: g_rows[r] = 4'($urandom & $urandom);
        endcase
      end
      run_case(i % 5 == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/grid_sweep_scheduler.md
# grid_sweep_scheduler

Row-serial controller that sequences repeated neighbour-count removal passes over a DEPTH×WIDTH occupancy grid held in internal storage. It accepts the grid one row per handshake, then runs full Jacobi-style passes, evaluating one row per cycle through a 3-row window. After each pass it reports the number of cells removed, and it stops when a pass removes nothing or a pass limit is reached. It is the sequenced, area-reduced replacement for the fully parallel sweep and sits between the grid loader and the result/readback logic.

## Interface
- WIDTH, 16, columns per row (bits per row word)
- DEPTH, 16, rows in the grid (DEPTH ≥ 2)
- MAX_PASSES, 256, maximum passes before forced stop (≥ 1)
- CW = $clog2(WIDTH*DEPTH+1), derived width of cell counts; PW = $clog2(MAX_PASSES+1), derived width of the pass counter

- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high; one clock, one synchronous active-high reset, named clk and reset
- load_valid  in  1  row word present on load_row
- load_ready  out  1  scheduler accepts a row this cycle
- load_row  in  WIDTH  row data, 1 = occupied; bit j = column j
- start  in  1  begin passes; honoured only in LOADED
- busy  out  1  high in SWEEP and CHECK
- pass_valid  out  1  one-cycle pulse per completed pass
- pass_removed  out  CW  cells removed in the pass; valid with pass_valid, held afterwards
- pass_count  out  PW  passes completed since start
- total_count  out  CW  cumulative cells removed since start
- done  out  1  level; high once the process terminates
- limit_hit  out  1  with done, set when termination was caused by MAX_PASSES
- rd_addr  in  $clog2(DEPTH)  readback row index
- rd_row  out  WIDTH  registered grid row rd_addr; 1-cycle latency

## Operation
- States: IDLE, LOAD, LOADED, SWEEP, CHECK, DONE.
- IDLE/LOAD: load_ready=1. Each load_valid&&load_ready writes load_row to row index ld_idx, which starts at 0 and then increments. When the write to row DEPTH-1 completes, go to LOADED (load_ready=0). The first accepted row moves IDLE→LOAD.
- LOADED: start=1 → SWEEP with row index 0. Clear pass_count, total_count and the pass accumulator. start in any other state is ignored.
- SWEEP: one row per cycle, r = 0..DEPTH-1. Row r's new value is computed from the pass-start values of rows r-1, r and r+1.
  - Before row r is overwritten, the scheduler saves its original value in a prev-row register, because row r+1 needs it.
  - Positions outside the grid count as 0.
  - A cell is cleared if it is 1 and fewer than 4 of its 8 neighbours are 1.
  - The popcount of cleared bits is added to the pass accumulator.
  - All decisions within a pass depend only on the pass-start grid.
  - After r = DEPTH-1 → CHECK.
- CHECK (one cycle):
  - pass_valid=1 and pass_removed=accumulator.
  - total_count += accumulator; pass_count += 1.
  - If accumulator==0 → DONE with limit_hit=0.
  - Else if the new pass_count==MAX_PASSES → DONE with limit_hit=1.
  - Else → SWEEP from row 0 with the accumulator cleared.
- DONE: done=1 and load_ready=1; outputs hold. An accepted row clears done/limit_hit, writes row 0, and moves to LOAD. The grid keeps the final state for readback until it is overwritten.
- rd_row is readable in every state. During SWEEP it returns the current storage, so it can be mid-pass.
- Arithmetic: the per-row popcount is at most WIDTH. total_count cannot exceed WIDTH*DEPTH, so CW never overflows. The neighbour count fits 4 bits.

## Timing
- Reset:
  - state=IDLE, ld_idx=0, load_ready=1.
  - busy=0, done=0, limit_hit=0, pass_valid=0.
  - pass_removed=0, pass_count=0, total_count=0, rd_row=0.
  - Grid contents are don't-care.
- Reset asserted in any state, including mid-LOAD or mid-SWEEP, aborts on the next edge with no pass_valid.
- Start accepted at edge t: SWEEP covers cycles t+1..t+DEPTH; CHECK/pass_valid is at cycle t+DEPTH+1.
- Each pass takes DEPTH+1 cycles. done rises on the edge after the final CHECK.
- busy rises the cycle after start is accepted and falls when done rises.
- load_valid while load_ready=0 is ignored and not stalled. The loader must hold the row until the handshake completes.

## Test plan
- WIDTH=DEPTH=4, load all-zero rows, start → pass_valid once at t+5, pass_removed=0; then done=1, total_count=0, pass_count=1, limit_hit=0.
- 4×4 all-ones → pass 1 removes 4 (corners), pass 2 removes 0; total_count=4, pass_count=2. rd_row rows 0 and 3 = 4'b0110, rows 1 and 2 = 4'b1111.
- 4×4 single 1 at (1,2) → pass_removed 1 then 0; total_count=1, pass_count=2; all rd_row=0.
- MAX_PASSES=1 with the all-ones grid → one pass_valid with 4; done=1, limit_hit=1, pass_count=1.
- Load stress:
  - Toggle load_valid every other cycle → exactly 4 rows accepted, load_ready=0 in LOADED.
  - start asserted during LOAD is ignored.
  - start in LOADED is accepted.
- Reset mid-SWEEP (cycle t+2) → the next cycle is IDLE with all outputs at reset values. A new load/start sequence then reproduces the all-ones results.
